// File: rtl/matrix_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
//
// Shared definitions for the matrix-calculator datapath blocks.
//   MAX_DIM   : maximum rows/columns of a packed matrix (packing stride)
//   ELEM_W    : element width in bits
//   SCAL_W    : scalar width in bits
//   MAT_W     : width of a packed 5x5 matrix (200 bits)
//   PROD_W    : full width of an element-by-scalar product
//   OFF_W     : width of a bit offset into a packed matrix
//   seq_state_t : IDLE / RUN / DONE states of the scalar-multiply sequencer
//   elem_offset : bit offset of element (row, col) inside a packed matrix
// ---------------------------------------------------------------------------
package matrix_pkg;

  localparam int MAX_DIM = 5;
  localparam int ELEM_W  = 8;
  localparam int SCAL_W  = 4;
  localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int PROD_W  = ELEM_W + SCAL_W;
  localparam int OFF_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Row-major packing with a fixed stride of MAX_DIM, regardless of the
  // active m x n size, so every block sees the same element positions.
  function automatic logic [OFF_W-1:0] elem_offset(input logic [2:0] row,
                                                   input logic [2:0] col);
    return OFF_W'((int'(row) * MAX_DIM + int'(col)) * ELEM_W);
  endfunction

endpackage

// File: rtl/scalar_mul_elem.sv
// ---------------------------------------------------------------------------
// scalar_mul_elem
//
// Combinational 8x4 unsigned multiply of one matrix element by a scalar,
// reduced back to element width.
//   elem    in  8  matrix element
//   scalar  in  4  unsigned scalar
//   product out 8  element * scalar, reduced to 8 bits
//
// Build option: SCALAR_MUL_SATURATE_EN
//   defined   : products above 255 clamp to 8'hFF
//   undefined : the low 8 bits are kept (modulo 256), matching the
//               combinational scalar-multiply path
// ---------------------------------------------------------------------------
module scalar_mul_elem
  import matrix_pkg::*;
(
  input  logic [ELEM_W-1:0] elem,
  input  logic [SCAL_W-1:0] scalar,
  output logic [ELEM_W-1:0] product
);

`ifdef SCALAR_MUL_SATURATE_EN
  logic [PROD_W-1:0] full_product;

  // Any bit set above the element width means the true product exceeds 255.
  assign full_product = PROD_W'(elem) * PROD_W'(scalar);
  assign product      = (full_product[PROD_W-1:ELEM_W] != '0) ?
                        {ELEM_W{1'b1}} : full_product[ELEM_W-1:0];
`else
  // An element-width multiply yields exactly the low bits of the full product.
  assign product = elem * ELEM_W'(scalar);
`endif

endmodule

// File: rtl/scalar_mul_sequencer.sv
// ---------------------------------------------------------------------------
// scalar_mul_sequencer
//
// Multi-cycle matrix-by-scalar multiply. One shared scalar_mul_elem is
// stepped over the active m x n region of a packed 5x5 matrix, one element
// per clock, in row-major order. Elements outside the region read as 0.
//
// Ports
//   clk           in  1    system clock, rising edge
//   reset         in  1    asynchronous reset, active low
//   start         in  1    request, only sampled in IDLE
//   abort         in  1    synchronous cancel back to IDLE (beats start)
//   m, n          in  3    row / column count, legal 1..5
//   scalar_value  in  4    unsigned scalar
//   matrix_a      in  200  packed input, element (i,j) at [(i*5+j)*8 +: 8]
//   result        out 200  packed product, same packing
//   busy          out 1    high while in RUN
//   done          out 1    one-cycle completion pulse (success or error)
//   result_valid  out 1    result holds a completed product
//   dim_err       out 1    last start was rejected for illegal dimensions
//
// Build option: SCALAR_MUL_SATURATE_EN (see scalar_mul_elem) selects
// saturating instead of wrapping products; timing is unchanged.
// ---------------------------------------------------------------------------
module scalar_mul_sequencer
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        m,
  input  logic [2:0]        n,
  input  logic [SCAL_W-1:0] scalar_value,
  input  logic [MAT_W-1:0]  matrix_a,
  output logic [MAT_W-1:0]  result,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic              dim_err
);

  seq_state_t        state;
  seq_state_t        next_state;

  logic [2:0]        lat_m;
  logic [2:0]        lat_n;
  logic [SCAL_W-1:0] lat_scalar;
  logic [MAT_W-1:0]  lat_a;

  logic [2:0]        row;
  logic [2:0]        col;

  logic              dims_ok;
  logic              last_col;
  logic              last_elem;
  logic [OFF_W-1:0]  elem_off;
  logic [ELEM_W-1:0] cur_elem;
  logic [ELEM_W-1:0] cur_prod;

  // Dimensions are checked on the live inputs because they are only
  // meaningful in the cycle the start is accepted.
  assign dims_ok = (m != 3'd0) && (m <= 3'(MAX_DIM)) &&
                   (n != 3'd0) && (n <= 3'(MAX_DIM));

  assign last_col  = (col == lat_n - 3'd1);
  assign last_elem = last_col && (row == lat_m - 3'd1);

  assign elem_off = elem_offset(row, col);
  assign cur_elem = lat_a[elem_off +: ELEM_W];

  scalar_mul_elem u_mul (
    .elem    (cur_elem),
    .scalar  (lat_scalar),
    .product (cur_prod)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. busy and done are decoded straight
  // from the state so they can never overlap and drop instantly on reset.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = dims_ok ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_elem) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (abort) begin
      next_state = IDLE;
    end
  end

  // Operand latches, index counters, result accumulation and status flags.
  // A rejected start still clears the previous result so stale data is not
  // mistaken for the outcome of the bad request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_m        <= 3'd0;
      lat_n        <= 3'd0;
      lat_scalar   <= '0;
      lat_a        <= '0;
      row          <= 3'd0;
      col          <= 3'd0;
      result       <= '0;
      result_valid <= 1'b0;
      dim_err      <= 1'b0;
    end else if (abort) begin
      row          <= 3'd0;
      col          <= 3'd0;
      result       <= '0;
      result_valid <= 1'b0;
      dim_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lat_m        <= m;
            lat_n        <= n;
            lat_scalar   <= scalar_value;
            lat_a        <= matrix_a;
            row          <= 3'd0;
            col          <= 3'd0;
            result       <= '0;
            result_valid <= 1'b0;
            dim_err      <= !dims_ok;
          end
        end
        RUN: begin
          result[elem_off +: ELEM_W] <= cur_prod;
          if (last_elem) begin
            row          <= 3'd0;
            col          <= 3'd0;
            result_valid <= 1'b1;
          end else if (last_col) begin
            col <= 3'd0;
            row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
